// File: rtl/dac_amp_scaler.sv
`default_nettype none
// ============================================================================
//  Module   : dac_amp_scaler
//  Brief    : Scales signed DDS cos/sin samples by a glitch-free-updated gain,
//             rounds, saturates and emits offset-binary DAC codes.
//  Revision : 1.0 - initial release
// ============================================================================
module dac_amp_scaler #(
    parameter int DAC_WIDTH  = 14,
    parameter int AMP_WIDTH  = 16,
    parameter int AMP_FRAC   = 15,
    parameter int ZC_TIMEOUT = 4096
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    input  logic signed [DAC_WIDTH-1:0] wave_1,
    input  logic signed [DAC_WIDTH-1:0] wave_2,
    input  logic        [31:0]          amp_in,
    output logic        [DAC_WIDTH-1:0] dac_data_1,
    output logic        [DAC_WIDTH-1:0] dac_data_2,
    output logic                        out_valid,
    output logic        [AMP_WIDTH-1:0] amp_active,
    output logic                        amp_pending
);

    localparam int c_PROD_W = DAC_WIDTH + AMP_WIDTH + 1;
    localparam int c_CNT_W  = (ZC_TIMEOUT > 1) ? $clog2(ZC_TIMEOUT) : 1;

    localparam logic signed [c_PROD_W-1:0] c_ROUND   = c_PROD_W'(2 ** (AMP_FRAC - 1));
    localparam logic signed [c_PROD_W-1:0] c_SAT_MAX = c_PROD_W'(2 ** (DAC_WIDTH - 1) - 1);
    localparam logic signed [c_PROD_W-1:0] c_SAT_MIN = ~c_SAT_MAX;

    localparam logic [0:0] c_ST_IDLE    = 1'b0;
    localparam logic [0:0] c_ST_WAIT_ZC = 1'b1;

    logic                        r_s1_v;
    logic signed [DAC_WIDTH-1:0] r_s1_w1;
    logic signed [DAC_WIDTH-1:0] r_s1_w2;
    logic                        r_prev_v;
    logic                        r_prev_neg;
    logic                        r_s2_v;
    logic signed [c_PROD_W-1:0]  r_s2_p1;
    logic signed [c_PROD_W-1:0]  r_s2_p2;
    logic                        r_out_v;
    logic        [DAC_WIDTH-1:0] r_dac_1;
    logic        [DAC_WIDTH-1:0] r_dac_2;

    logic [0:0]           r_state;
    logic [0:0]           w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nx;
    logic [AMP_WIDTH-1:0] r_amp_active;
    logic [AMP_WIDTH-1:0] w_amp_nx;
    logic                 r_amp_pending;
    logic                 w_pend_nx;

    logic [AMP_WIDTH-1:0]       w_amp_tgt;
    logic                       w_zc;
    logic                       w_timeout;
    logic signed [c_PROD_W-1:0] w_w1_ext;
    logic signed [c_PROD_W-1:0] w_w2_ext;
    logic signed [c_PROD_W-1:0] w_gain_ext;

    assign w_amp_tgt  = (|amp_in[31:AMP_WIDTH]) ? {AMP_WIDTH{1'b1}} : amp_in[AMP_WIDTH-1:0];
    assign w_zc       = r_s1_v & r_prev_v & (r_s1_w1[DAC_WIDTH-1] ^ r_prev_neg);
    assign w_timeout  = (r_cnt == c_CNT_W'(ZC_TIMEOUT - 1));
    assign w_w1_ext   = {{(AMP_WIDTH + 1){r_s1_w1[DAC_WIDTH-1]}}, r_s1_w1};
    assign w_w2_ext   = {{(AMP_WIDTH + 1){r_s1_w2[DAC_WIDTH-1]}}, r_s1_w2};
    assign w_gain_ext = {{(DAC_WIDTH + 1){1'b0}}, r_amp_active};

    // Round half-up, saturate, then flip the sign bit to get offset binary.
    function automatic logic [DAC_WIDTH-1:0] sat_ob(input logic signed [c_PROD_W-1:0] p);
        logic signed [c_PROD_W-1:0] r;
        logic        [DAC_WIDTH-1:0] s;
        r = (p + c_ROUND) >>> AMP_FRAC;
        if (r > c_SAT_MAX)
            s = c_SAT_MAX[DAC_WIDTH-1:0];
        else if (r < c_SAT_MIN)
            s = c_SAT_MIN[DAC_WIDTH-1:0];
        else
            s = r[DAC_WIDTH-1:0];
        return {~s[DAC_WIDTH-1], s[DAC_WIDTH-2:0]};
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_v     <= 1'b0;
            r_s1_w1    <= '0;
            r_s1_w2    <= '0;
            r_prev_v   <= 1'b0;
            r_prev_neg <= 1'b0;
            r_s2_v     <= 1'b0;
            r_s2_p1    <= '0;
            r_s2_p2    <= '0;
            r_out_v    <= 1'b0;
            r_dac_1    <= '0;
            r_dac_2    <= '0;
        end else begin
            r_s1_v     <= in_valid;
            r_s1_w1    <= wave_1;
            r_s1_w2    <= wave_2;
            r_prev_v   <= r_s1_v;
            r_prev_neg <= r_s1_w1[DAC_WIDTH-1];
            r_s2_v     <= r_s1_v;
            // Both channels share one gain value in the same cycle.
            r_s2_p1    <= w_w1_ext * w_gain_ext;
            r_s2_p2    <= w_w2_ext * w_gain_ext;
            r_out_v    <= r_s2_v;
            r_dac_1    <= r_s2_v ? sat_ob(r_s2_p1) : '0;
            r_dac_2    <= r_s2_v ? sat_ob(r_s2_p2) : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_amp_active  <= '0;
            r_amp_pending <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_amp_active  <= w_amp_nx;
            r_amp_pending <= w_pend_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_amp_nx   = r_amp_active;
        w_pend_nx  = r_amp_pending;
        case (r_state)
            c_ST_IDLE: begin
                if (w_amp_tgt != r_amp_active) begin
                    if (!r_s1_v) begin
                        w_amp_nx = w_amp_tgt;
                    end else begin
                        w_state_nx = c_ST_WAIT_ZC;
                        w_cnt_nx   = '0;
                        w_pend_nx  = 1'b1;
                    end
                end
            end
            c_ST_WAIT_ZC: begin
                w_cnt_nx = r_cnt + c_CNT_W'(1);
                // A request that reverts to the active gain is simply dropped.
                if (w_amp_tgt == r_amp_active) begin
                    w_state_nx = c_ST_IDLE;
                    w_pend_nx  = 1'b0;
                end else if (w_zc || w_timeout || !r_s1_v) begin
                    w_amp_nx   = w_amp_tgt;
                    w_state_nx = c_ST_IDLE;
                    w_pend_nx  = 1'b0;
                end
            end
            default: begin
                w_state_nx = c_ST_IDLE;
                w_pend_nx  = 1'b0;
            end
        endcase
    end

    assign dac_data_1  = r_dac_1;
    assign dac_data_2  = r_dac_2;
    assign out_valid   = r_out_v;
    assign amp_active  = r_amp_active;
    assign amp_pending = r_amp_pending;

endmodule
`default_nettype wire

// File: tb/tb_dac_amp_scaler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_amp_scaler
//  Brief    : Self-checking bench for dac_amp_scaler with a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dac_amp_scaler;

    localparam int DAC_WIDTH  = 14;
    localparam int AMP_WIDTH  = 16;
    localparam int AMP_FRAC   = 15;
    localparam int ZC_TIMEOUT = 4096;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        in_valid;
    logic signed [DAC_WIDTH-1:0] wave_1;
    logic signed [DAC_WIDTH-1:0] wave_2;
    logic        [31:0]          amp_in;
    logic        [DAC_WIDTH-1:0] dac_data_1;
    logic        [DAC_WIDTH-1:0] dac_data_2;
    logic                        out_valid;
    logic        [AMP_WIDTH-1:0] amp_active;
    logic                        amp_pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dac_amp_scaler #(
        .DAC_WIDTH (DAC_WIDTH),
        .AMP_WIDTH (AMP_WIDTH),
        .AMP_FRAC  (AMP_FRAC),
        .ZC_TIMEOUT(ZC_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .wave_1     (wave_1),
        .wave_2     (wave_2),
        .amp_in     (amp_in),
        .dac_data_1 (dac_data_1),
        .dac_data_2 (dac_data_2),
        .out_valid  (out_valid),
        .amp_active (amp_active),
        .amp_pending(amp_pending)
    );

    // Reference model state: samples travel with the gain they were scaled by.
    bit m_s1v, m_pv, m_s2v, m_ov, m_pend, m_wait;
    int m_s1w1, m_s1w2, m_pw1, m_s2w1, m_s2w2, m_s2g, m_d1, m_d2, m_gain, m_el;

    function automatic int exp_code(input int w, input int g);
        longint div, p, q;
        div = longint'(1) << AMP_FRAC;
        p   = longint'(w) * longint'(g) + div / 2;
        if (p >= 0) q = p / div;
        else        q = -((-p + div - 1) / div);
        if (q > (2 ** (DAC_WIDTH - 1)) - 1) q = (2 ** (DAC_WIDTH - 1)) - 1;
        if (q < -(2 ** (DAC_WIDTH - 1)))    q = -(2 ** (DAC_WIDTH - 1));
        return int'(q) + 2 ** (DAC_WIDTH - 1);
    endfunction

    task automatic model_reset();
        m_s1v = 0; m_pv = 0; m_s2v = 0; m_ov = 0; m_pend = 0; m_wait = 0;
        m_s1w1 = 0; m_s1w2 = 0; m_pw1 = 0; m_s2w1 = 0; m_s2w2 = 0; m_s2g = 0;
        m_d1 = 0; m_d2 = 0; m_gain = 0; m_el = 0;
    endtask

    // Apply one cycle of inputs, advance the model, land 1 time unit after the edge.
    task automatic step(input bit v, input int w1, input int w2, input logic [31:0] a);
        int  tgt, n_gain, n_el;
        bit  zc, n_pend, n_wait;
        in_valid = v;
        wave_1   = DAC_WIDTH'(w1);
        wave_2   = DAC_WIDTH'(w2);
        amp_in   = a;
        tgt    = (a > 32'hFFFF) ? 65535 : int'(a);
        zc     = m_s1v && m_pv && ((m_s1w1 < 0) != (m_pw1 < 0));
        n_gain = m_gain; n_pend = m_pend; n_wait = m_wait; n_el = m_el + 1;
        if (!m_wait) begin
            if (tgt != m_gain) begin
                if (!m_s1v) n_gain = tgt;
                else begin n_wait = 1; n_pend = 1; n_el = 0; end
            end
        end else if (tgt == m_gain) begin
            n_wait = 0; n_pend = 0;
        end else if (zc || m_el == ZC_TIMEOUT - 1 || !m_s1v) begin
            n_gain = tgt; n_wait = 0; n_pend = 0;
        end
        m_ov = m_s2v;
        m_d1 = m_s2v ? exp_code(m_s2w1, m_s2g) : 0;
        m_d2 = m_s2v ? exp_code(m_s2w2, m_s2g) : 0;
        m_s2v = m_s1v; m_s2w1 = m_s1w1; m_s2w2 = m_s1w2; m_s2g = m_gain;
        m_pv = m_s1v; m_pw1 = m_s1w1;
        m_s1v = v; m_s1w1 = w1; m_s1w2 = w2;
        m_gain = n_gain; m_pend = n_pend; m_wait = n_wait; m_el = n_el;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; wave_1 = '0; wave_2 = '0; amp_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dac_data_1 !== 0 || dac_data_2 !== 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got d1=%0d d2=%0d v=%b, expected 0 0 0", dac_data_1, dac_data_2, out_valid);
        end
        n_checks++;
        if (amp_active !== 0 || amp_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gain: got amp=%h pend=%b, expected 0 0", amp_active, amp_pending);
        end
        #3 rstn = 1'b1;
    endtask

    task automatic test_unity();
        step(0, 0, 0, 32'h8000);
        n_checks++;
        if (amp_active !== 16'h8000) begin
            n_fail++;
            $display("FAIL unity_immediate_load: got %h, expected 8000", amp_active);
        end
        step(1, 1000, -1000, 32'h8000);
        step(0, 0, 0, 32'h8000);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL unity_latency_early: got out_valid=%b, expected 0", out_valid);
        end
        step(0, 0, 0, 32'h8000);
        n_checks++;
        if (out_valid !== 1'b1 || dac_data_1 !== 14'd9192 || dac_data_2 !== 14'd7192) begin
            n_fail++;
            $display("FAIL unity_values: got v=%b d1=%0d d2=%0d, expected 1 9192 7192", out_valid, dac_data_1, dac_data_2);
        end
        step(0, 0, 0, 32'h8000);
        n_checks++;
        if (out_valid !== 1'b0 || dac_data_1 !== 0) begin
            n_fail++;
            $display("FAIL unity_flush: got v=%b d1=%0d, expected 0 0", out_valid, dac_data_1);
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 0, 32'hFFFF);
        step(1, 8191, -8192, 32'hFFFF);
        step(1, -8192, 8191, 32'hFFFF);
        step(0, 0, 0, 32'hFFFF);
        n_checks++;
        if (dac_data_1 !== 14'd16383 || dac_data_2 !== 14'd0) begin
            n_fail++;
            $display("FAIL sat_pos_neg: got d1=%0d d2=%0d, expected 16383 0", dac_data_1, dac_data_2);
        end
        step(0, 0, 0, 32'hFFFF);
        n_checks++;
        if (dac_data_1 !== 14'd0 || dac_data_2 !== 14'd16383) begin
            n_fail++;
            $display("FAIL sat_neg_pos: got d1=%0d d2=%0d, expected 0 16383", dac_data_1, dac_data_2);
        end
        step(0, 0, 0, 32'hFFFF_FFFF);
        step(1, 8191, -8192, 32'hFFFF_FFFF);
        n_checks++;
        if (amp_active !== 16'hFFFF || amp_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_clamp_gain: got amp=%h pend=%b, expected ffff 0", amp_active, amp_pending);
        end
        step(0, 0, 0, 32'hFFFF_FFFF);
        step(0, 0, 0, 32'hFFFF_FFFF);
        n_checks++;
        if (out_valid !== 1'b1 || dac_data_1 !== 14'd16383 || dac_data_2 !== 14'd0) begin
            n_fail++;
            $display("FAIL sat_clamp_out: got v=%b d1=%0d d2=%0d, expected 1 16383 0", out_valid, dac_data_1, dac_data_2);
        end
        step(0, 0, 0, 32'hFFFF_FFFF);
    endtask

    task automatic test_rounding();
        int wv[6]  = '{3, -3, 1, 0, 0, 0};
        int ex[6]  = '{0, 0, 8194, 8191, 8193, 0};
        step(0, 0, 0, 32'h4000);
        n_checks++;
        if (amp_active !== 16'h4000) begin
            n_fail++;
            $display("FAIL round_gain: got %h, expected 4000", amp_active);
        end
        for (int i = 0; i < 6; i++) begin
            step(i < 3, wv[i], 0, 32'h4000);
            if (i >= 2 && i < 5) begin
                n_checks++;
                if (out_valid !== 1'b1 || dac_data_1 !== 14'(ex[i])) begin
                    n_fail++;
                    $display("FAIL round_half_up[%0d]: got v=%b d1=%0d, expected 1 %0d", i - 2, out_valid, dac_data_1, ex[i]);
                end
            end
        end
    endtask

    task automatic test_zero_crossing();
        int w1, w2, first_neg;
        logic [31:0] a;
        first_neg = -1;
        step(0, 0, 0, 32'h8000);
        step(0, 0, 0, 32'h8000);
        for (int n = 0; n < 40; n++) begin
            w1 = int'(4000.0 * $sin(6.283185307 * n / 40.0));
            w2 = int'(4000.0 * $cos(6.283185307 * n / 40.0));
            a  = (n >= 5) ? 32'h4000 : 32'h8000;
            if (first_neg < 0 && n >= 5 && w1 < 0) first_neg = n;
            step(1, w1, w2, a);
            n_checks++;
            if (out_valid !== m_ov || dac_data_1 !== 14'(m_d1) || dac_data_2 !== 14'(m_d2)) begin
                n_fail++;
                $display("FAIL zc_outputs n=%0d: got v=%b %0d %0d, expected %b %0d %0d", n, out_valid, dac_data_1, dac_data_2, m_ov, m_d1, m_d2);
            end
            n_checks++;
            if (amp_active !== 16'(m_gain) || amp_pending !== m_pend) begin
                n_fail++;
                $display("FAIL zc_gain n=%0d: got amp=%h pend=%b, expected %h %b", n, amp_active, amp_pending, m_gain, m_pend);
            end
            if (n == first_neg) begin
                n_checks++;
                if (amp_pending !== 1'b1 || amp_active !== 16'h8000) begin
                    n_fail++;
                    $display("FAIL zc_no_early_load: got amp=%h pend=%b, expected 8000 1", amp_active, amp_pending);
                end
            end
            if (first_neg >= 0 && n == first_neg + 1) begin
                n_checks++;
                if (amp_pending !== 1'b0 || amp_active !== 16'h4000) begin
                    n_fail++;
                    $display("FAIL zc_load_at_crossing: got amp=%h pend=%b, expected 4000 0", amp_active, amp_pending);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int cnt;
        repeat (3) step(1, 500, 500, 32'h4000);
        step(1, 500, 500, 32'h6000);
        n_checks++;
        if (amp_pending !== 1'b1 || amp_active !== 16'h4000) begin
            n_fail++;
            $display("FAIL timeout_enter: got amp=%h pend=%b, expected 4000 1", amp_active, amp_pending);
        end
        cnt = 0;
        while (amp_pending === 1'b1 && cnt < ZC_TIMEOUT + 8) begin
            step(1, 500, 500, 32'h6000);
            cnt++;
            n_checks++;
            if (amp_active !== 16'(m_gain) || amp_pending !== m_pend || dac_data_1 !== 14'(m_d1)) begin
                n_fail++;
                $display("FAIL timeout_track c=%0d: got amp=%h pend=%b d1=%0d, expected %h %b %0d", cnt, amp_active, amp_pending, dac_data_1, m_gain, m_pend, m_d1);
            end
        end
        n_checks++;
        if (cnt != ZC_TIMEOUT || amp_active !== 16'h6000) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d cycles amp=%h, expected %0d 6000", cnt, amp_active, ZC_TIMEOUT);
        end
    endtask

    task automatic test_toggle_back();
        logic [31:0] seq[8] = '{32'h6000, 32'h2000, 32'h2000, 32'h2000, 32'h3000, 32'h3000, 32'h3000, 32'h6000};
        for (int i = 0; i < 8; i++) begin
            step(1, 500, 500, seq[i]);
            n_checks++;
            if (amp_active !== 16'h6000 || amp_pending !== m_pend) begin
                n_fail++;
                $display("FAIL toggle_no_load[%0d]: got amp=%h pend=%b, expected 6000 %b", i, amp_active, amp_pending, m_pend);
            end
        end
        n_checks++;
        if (amp_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_return_idle: got pend=%b, expected 0", amp_pending);
        end
    endtask

    task automatic test_async_reset();
        step(1, 500, 500, 32'h1000);
        n_checks++;
        if (amp_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_pending: got %b, expected 1", amp_pending);
        end
        #3 rstn = 1'b0;
        amp_in = 32'h0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || dac_data_1 !== 0 || dac_data_2 !== 0 || amp_active !== 0 || amp_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got v=%b %0d %0d amp=%h pend=%b, expected all 0", out_valid, dac_data_1, dac_data_2, amp_active, amp_pending);
        end
        model_reset();
        #2 rstn = 1'b1;
        step(1, -700, 700, 32'h0);
        step(0, 0, 0, 32'h0);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_latency: got out_valid=%b, expected 0", out_valid);
        end
        step(0, 0, 0, 32'h0);
        n_checks++;
        if (out_valid !== 1'b1 || dac_data_1 !== 14'd8192 || dac_data_2 !== 14'd8192) begin
            n_fail++;
            $display("FAIL zero_gain_midscale: got v=%b %0d %0d, expected 1 8192 8192", out_valid, dac_data_1, dac_data_2);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        a = 32'h8000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0)
                a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 65535));
            step($urandom_range(0, 99) < 85, int'($urandom_range(0, 16383)) - 8192,
                 int'($urandom_range(0, 16383)) - 8192, a);
            n_checks++;
            if (out_valid !== m_ov || dac_data_1 !== 14'(m_d1) || dac_data_2 !== 14'(m_d2)) begin
                n_fail++;
                $display("FAIL rand_outputs i=%0d: got v=%b %0d %0d, expected %b %0d %0d", i, out_valid, dac_data_1, dac_data_2, m_ov, m_d1, m_d2);
            end
            n_checks++;
            if (amp_active !== 16'(m_gain) || amp_pending !== m_pend) begin
                n_fail++;
                $display("FAIL rand_gain i=%0d: got amp=%h pend=%b, expected %h %b", i, amp_active, amp_pending, m_gain, m_pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_saturation();
        test_rounding();
        test_zero_crossing();
        test_timeout();
        test_toggle_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
